// File: rtl/router_ctrl_if.sv
// Bundle of the packet source, FIFO status and FIFO write-side signals
// seen by the router write controller. The controller uses the slave view;
// the driving environment uses the master view.
interface router_ctrl_if #(
  parameter int DW = 3
);
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic [2:0]    fifo_full;
  logic [2:0]    fifo_empty;
  logic [2:0]    read_enb;
  logic [DW-1:0] fifo_din;
  logic [2:0]    write_enb;
  logic          lfd_state;
  logic          busy;
  logic [2:0]    soft_reset;
  logic          parity_done;
  logic          err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  fifo_din, write_enb, lfd_state, busy, soft_reset, parity_done, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output fifo_din, write_enb, lfd_state, busy, soft_reset, parity_done, err
  );
endinterface

// File: rtl/router_ctrl.sv
// Router write controller: decodes the header destination, sequences the
// header/payload/parity writes into one of three FIFOs, stalls the source
// while the FIFO is full or still draining, checks packet parity and issues
// a per-FIFO soft reset when a non-empty FIFO goes unread too long.
module router_ctrl #(
  parameter int DW      = 3,
  parameter int TIMEOUT = 30
) (
  input logic          clock,
  input logic          reset,
  router_ctrl_if.slave bus
);

  localparam logic [3:0] S_DECODE          = 4'd0;
  localparam logic [3:0] S_WAIT_EMPTY      = 4'd1;
  localparam logic [3:0] S_LOAD_FIRST      = 4'd2;
  localparam logic [3:0] S_LOAD_DATA       = 4'd3;
  localparam logic [3:0] S_FULL            = 4'd4;
  localparam logic [3:0] S_LOAD_AFTER_FULL = 4'd5;
  localparam logic [3:0] S_LOAD_PARITY     = 4'd6;
  localparam logic [3:0] S_CHECK           = 4'd7;
  localparam logic [3:0] S_DROP            = 4'd8;

  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  logic [3:0]      state_q, state_d;
  logic [1:0]      dest_q, dest_d;
  logic [DW-1:0]   hdr_q, hdr_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic            err_q, err_d;
  logic [2:0][4:0] cnt_q, cnt_d;

  logic [2:0]      sr_s;
  logic [3:0]      empty_x_s, full_x_s, sr_x_s;
  logic [1:0]      hdr_dest_s;
  logic            abort_s;
  logic            we_s, lfd_s, busy_s, pd_s;
  logic [DW-1:0]   din_s;

  // Flags widened to four entries so a 2-bit destination never indexes out of range.
  always_comb begin
    empty_x_s  = {1'b0, bus.fifo_empty};
    full_x_s   = {1'b0, bus.fifo_full};
    sr_x_s     = {1'b0, sr_s};
    hdr_dest_s = bus.data_in[1:0];
    abort_s    = sr_x_s[dest_q] && (state_q != S_DECODE) && (state_q != S_DROP);
  end

  // Per-FIFO read timeout: count unread non-empty cycles, pulse and restart on the last one.
  always_comb begin
    sr_s  = 3'b000;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (bus.fifo_empty[i] || bus.read_enb[i]) begin
        cnt_d[i] = 5'd0;
      end else if (cnt_q[i] == TO_LAST) begin
        sr_s[i]  = 1'b1;
        cnt_d[i] = 5'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 5'd1;
      end
    end
  end

  // Packet sequencing FSM: next state, data holders and write-side decodes.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    hdr_d   = hdr_q;
    hold_d  = hold_q;
    acc_d   = acc_q;
    rx_d    = rx_q;
    err_d   = err_q;
    we_s    = 1'b0;
    lfd_s   = 1'b0;
    busy_s  = 1'b0;
    pd_s    = 1'b0;
    din_s   = {DW{1'b0}};
    case (state_q)
      S_DECODE: begin
        if (bus.pkt_valid && (hdr_dest_s != 2'd3)) begin
          dest_d  = hdr_dest_s;
          hdr_d   = bus.data_in;
          acc_d   = bus.data_in;
          state_d = empty_x_s[hdr_dest_s] ? S_LOAD_FIRST : S_WAIT_EMPTY;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_WAIT_EMPTY: begin
        busy_s = 1'b1;
        if (empty_x_s[dest_q]) begin
          state_d = S_LOAD_FIRST;
        end else begin
          state_d = S_WAIT_EMPTY;
        end
      end
      S_LOAD_FIRST: begin
        busy_s  = 1'b1;
        we_s    = 1'b1;
        lfd_s   = 1'b1;
        din_s   = hdr_q;
        state_d = S_LOAD_DATA;
        if (!abort_s) begin
          err_d = 1'b0;
        end else begin
          err_d = err_q;
        end
      end
      S_LOAD_DATA: begin
        din_s = bus.data_in;
        if (bus.pkt_valid) begin
          if (!full_x_s[dest_q]) begin
            we_s  = 1'b1;
            acc_d = acc_q ^ bus.data_in;
          end else begin
            hold_d  = bus.data_in;
            state_d = S_FULL;
          end
        end else begin
          rx_d    = bus.data_in;
          state_d = S_LOAD_PARITY;
        end
      end
      S_FULL: begin
        busy_s = 1'b1;
        if (!full_x_s[dest_q]) begin
          state_d = S_LOAD_AFTER_FULL;
        end else begin
          state_d = S_FULL;
        end
      end
      S_LOAD_AFTER_FULL: begin
        busy_s  = 1'b1;
        we_s    = 1'b1;
        din_s   = hold_q;
        acc_d   = acc_q ^ hold_q;
        state_d = S_LOAD_DATA;
      end
      S_LOAD_PARITY: begin
        busy_s = 1'b1;
        if (full_x_s[dest_q]) begin
          state_d = S_LOAD_PARITY;
        end else begin
          we_s    = 1'b1;
          din_s   = rx_q;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy_s  = 1'b1;
        state_d = S_DECODE;
        if (!abort_s) begin
          pd_s  = 1'b1;
          err_d = (acc_q != rx_q);
        end else begin
          err_d = err_q;
        end
      end
      S_DROP: begin
        if (!bus.pkt_valid) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_DECODE;
      end
    endcase
    // A timeout on the active destination abandons the packet.
    if (abort_s) begin
      state_d = bus.pkt_valid ? S_DROP : S_DECODE;
    end else begin
      state_d = state_d;
    end
  end

  // Output drive; everything is held low during the reset cycle.
  always_comb begin
    if (reset) begin
      bus.fifo_din    = {DW{1'b0}};
      bus.write_enb   = 3'b000;
      bus.lfd_state   = 1'b0;
      bus.busy        = 1'b0;
      bus.soft_reset  = 3'b000;
      bus.parity_done = 1'b0;
      bus.err         = 1'b0;
    end else begin
      bus.fifo_din    = din_s;
      bus.write_enb   = we_s ? (3'b001 << dest_q) : 3'b000;
      bus.lfd_state   = lfd_s;
      bus.busy        = busy_s;
      bus.soft_reset  = sr_s;
      bus.parity_done = pd_s;
      bus.err         = err_q;
    end
  end

  // State and data-holder registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_DECODE;
      dest_q  <= 2'd0;
      hdr_q   <= {DW{1'b0}};
      hold_q  <= {DW{1'b0}};
      acc_q   <= {DW{1'b0}};
      rx_q    <= {DW{1'b0}};
      err_q   <= 1'b0;
      cnt_q   <= {3{5'd0}};
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      hdr_q   <= hdr_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: a table of per-cycle vectors plus hand-written
// timeout/abort sequences. Expected outputs are queued when a vector is
// driven and popped when the outputs are sampled on the falling edge.
module tb_router_ctrl;

  localparam logic [2:0] Z3 = 3'b000;
  localparam logic [2:0] E7 = 3'b111;
  localparam logic       L0 = 1'b0;
  localparam logic       L1 = 1'b1;

  typedef struct packed {
    logic [2:0] din;
    logic [2:0] we;
    logic       lfd;
    logic       busy;
    logic [2:0] sr;
    logic       pd;
    logic       err;
  } out_t;

  typedef struct {
    string      nm;
    logic       rst;
    logic       pv;
    logic [2:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] ren;
    out_t       exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_ctrl_if #(.DW(3)) bus ();

  router_ctrl #(.DW(3), .TIMEOUT(30)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;

  function automatic vec_t mk(input string nm, input logic rst, input logic pv,
                              input logic [2:0] din, input logic [2:0] full,
                              input logic [2:0] empty, input logic [2:0] ren,
                              input logic [2:0] edin, input logic [2:0] ewe,
                              input logic elfd, input logic ebusy,
                              input logic [2:0] esr, input logic epd, input logic eerr);
    vec_t v;
    v.nm = nm; v.rst = rst; v.pv = pv; v.din = din;
    v.full = full; v.empty = empty; v.ren = ren;
    v.exp = '{din: edin, we: ewe, lfd: elfd, busy: ebusy, sr: esr, pd: epd, err: eerr};
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare at the falling edge.
  task automatic step(input vec_t v);
    out_t act;
    out_t exp;
    @(posedge clock);
    #1;
    reset          = v.rst;
    bus.pkt_valid  = v.pv;
    bus.data_in    = v.din;
    bus.fifo_full  = v.full;
    bus.fifo_empty = v.empty;
    bus.read_enb   = v.ren;
    exp_q.push_back(v.exp);
    @(negedge clock);
    act = {bus.fifo_din, bus.write_enb, bus.lfd_state, bus.busy,
           bus.soft_reset, bus.parity_done, bus.err};
    if (bus.write_enb != 3'b000) n_writes++;
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got din=%b we=%b lfd=%b busy=%b sr=%b pd=%b err=%b, expected din=%b we=%b lfd=%b busy=%b sr=%b pd=%b err=%b",
               v.nm, act.din, act.we, act.lfd, act.busy, act.sr, act.pd, act.err,
               exp.din, exp.we, exp.lfd, exp.busy, exp.sr, exp.pd, exp.err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  initial begin
    int p4_lo;
    int p4_hi;
    int w0;
    reset          = 1'b1;
    bus.pkt_valid  = 1'b0;
    bus.data_in    = 3'b000;
    bus.fifo_full  = 3'b000;
    bus.fifo_empty = 3'b111;
    bus.read_enb   = 3'b000;
    w0 = 0;

    // reset state
    vecs.push_back(mk("rst0",   L1,L1,3'b001,Z3,E7,Z3, Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("rst1",   L1,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("idle",   L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    // port 1, good parity (001^101^110 = 010)
    vecs.push_back(mk("p1_hdr", L0,L1,3'b001,Z3,E7,Z3, Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p1_lf",  L0,L1,3'b101,Z3,E7,Z3, 3'b001,3'b010,L1,L1,Z3,L0,L0));
    vecs.push_back(mk("p1_d0",  L0,L1,3'b101,Z3,E7,Z3, 3'b101,3'b010,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p1_d1",  L0,L1,3'b110,Z3,E7,Z3, 3'b110,3'b010,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p1_par", L0,L0,3'b010,Z3,E7,Z3, 3'b010,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p1_lp",  L0,L0,Z3,Z3,E7,Z3,     3'b010,3'b010,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p1_chk", L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L1,Z3,L1,L0));
    vecs.push_back(mk("p1_end", L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    // same packet, bad parity 000 -> err
    vecs.push_back(mk("p2_hdr", L0,L1,3'b001,Z3,E7,Z3, Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p2_lf",  L0,L1,3'b101,Z3,E7,Z3, 3'b001,3'b010,L1,L1,Z3,L0,L0));
    vecs.push_back(mk("p2_d0",  L0,L1,3'b101,Z3,E7,Z3, 3'b101,3'b010,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p2_d1",  L0,L1,3'b110,Z3,E7,Z3, 3'b110,3'b010,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p2_par", L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p2_lp",  L0,L0,Z3,Z3,E7,Z3,     Z3,3'b010,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p2_chk", L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L1,Z3,L1,L0));
    vecs.push_back(mk("p2_end", L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L1));
    // port 2 not yet drained -> WAIT_EMPTY; err clears after LOAD_FIRST
    vecs.push_back(mk("p3_hdr", L0,L1,3'b010,Z3,3'b011,Z3, Z3,Z3,L0,L0,Z3,L0,L1));
    vecs.push_back(mk("p3_w0",  L0,L1,3'b111,Z3,3'b011,Z3, Z3,Z3,L0,L1,Z3,L0,L1));
    vecs.push_back(mk("p3_w1",  L0,L1,3'b111,Z3,E7,Z3,     Z3,Z3,L0,L1,Z3,L0,L1));
    vecs.push_back(mk("p3_lf",  L0,L1,3'b111,Z3,E7,Z3,     3'b010,3'b100,L1,L1,Z3,L0,L1));
    vecs.push_back(mk("p3_d0",  L0,L1,3'b111,Z3,E7,Z3,     3'b111,3'b100,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p3_par", L0,L0,3'b101,Z3,E7,Z3,     3'b101,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p3_lp",  L0,L0,Z3,Z3,E7,Z3,         3'b101,3'b100,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p3_chk", L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L1,Z3,L1,L0));
    vecs.push_back(mk("p3_end", L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L0,Z3,L0,L0));
    // port 0, FIFO fills while 011 is presented
    p4_lo = vecs.size();
    vecs.push_back(mk("p4_hdr", L0,L1,Z3,Z3,E7,Z3,         Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p4_lf",  L0,L1,3'b001,Z3,E7,Z3,     Z3,3'b001,L1,L1,Z3,L0,L0));
    vecs.push_back(mk("p4_d0",  L0,L1,3'b001,Z3,E7,Z3,     3'b001,3'b001,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p4_full",L0,L1,3'b011,3'b001,E7,Z3, 3'b011,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p4_f0",  L0,L1,3'b100,3'b001,E7,Z3, Z3,Z3,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p4_f1",  L0,L1,3'b100,Z3,E7,Z3,     Z3,Z3,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p4_laf", L0,L1,3'b100,Z3,E7,Z3,     3'b011,3'b001,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p4_d1",  L0,L1,3'b100,Z3,E7,Z3,     3'b100,3'b001,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p4_par", L0,L0,3'b110,Z3,E7,Z3,     3'b110,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("p4_lp",  L0,L0,Z3,Z3,E7,Z3,         3'b110,3'b001,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("p4_chk", L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L1,Z3,L1,L0));
    vecs.push_back(mk("p4_end", L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L0,Z3,L0,L0));
    p4_hi = vecs.size();
    // dest 3 header is ignored
    vecs.push_back(mk("d3_hdr", L0,L1,3'b011,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("d3_idle",L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L0,Z3,L0,L0));
    // reset mid-payload, then a fresh packet to port 2
    vecs.push_back(mk("rs_hdr", L0,L1,3'b001,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("rs_lf",  L0,L1,3'b101,Z3,E7,Z3,     3'b001,3'b010,L1,L1,Z3,L0,L0));
    vecs.push_back(mk("rs_mid", L1,L1,3'b101,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("rs_idle",L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("rs_hdr2",L0,L1,3'b010,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("rs_lf2", L0,L0,3'b010,Z3,E7,Z3,     3'b010,3'b100,L1,L1,Z3,L0,L0));
    vecs.push_back(mk("rs_par", L0,L0,3'b010,Z3,E7,Z3,     3'b010,Z3,L0,L0,Z3,L0,L0));
    vecs.push_back(mk("rs_lp",  L0,L0,Z3,Z3,E7,Z3,         3'b010,3'b100,L0,L1,Z3,L0,L0));
    vecs.push_back(mk("rs_chk", L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L1,Z3,L1,L0));
    vecs.push_back(mk("rs_end", L0,L0,Z3,Z3,E7,Z3,         Z3,Z3,L0,L0,Z3,L0,L0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == p4_lo) w0 = n_writes;
      if (i == p4_hi) begin
        n_checks++;
        if ((n_writes - w0) != 5) begin
          n_fail++;
          $display("FAIL p4_write_count: got %0d writes, expected 5", n_writes - w0);
        end
      end
      step(vecs[i]);
    end

    // FIFO 1 non-empty and unread: pulse on the 30th cycle only
    for (int k = 1; k <= 30; k++) begin
      step(mk("to_a", L0,L0,Z3,Z3,3'b101,Z3, Z3,Z3,L0,L0,(k == 30) ? 3'b010 : Z3,L0,L0));
    end
    // read pulse on cycle 20 restarts the count; a header to port 0 in the pulse cycle is accepted
    for (int k = 1; k <= 50; k++) begin
      step(mk("to_b", L0,(k == 50),Z3,Z3,3'b101,(k == 20) ? 3'b010 : Z3,
              Z3,Z3,L0,L0,(k == 50) ? 3'b010 : Z3,L0,L0));
    end
    step(mk("to_lf",  L0,L0,Z3,Z3,E7,Z3, Z3,3'b001,L1,L1,Z3,L0,L0));
    step(mk("to_par", L0,L0,Z3,Z3,E7,Z3, Z3,Z3,L0,L0,Z3,L0,L0));
    step(mk("to_lp",  L0,L0,Z3,Z3,E7,Z3, Z3,3'b001,L0,L1,Z3,L0,L0));
    step(mk("to_chk", L0,L0,Z3,Z3,E7,Z3, Z3,Z3,L0,L1,Z3,L1,L0));

    // timeout on the active destination aborts into DROP, then DECODE
    step(mk("ab_hdr", L0,L1,3'b001,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    step(mk("ab_lf",  L0,L1,3'b100,Z3,3'b101,Z3, 3'b001,3'b010,L1,L1,Z3,L0,L0));
    for (int k = 2; k <= 30; k++) begin
      step(mk("ab_ld", L0,L1,3'b100,Z3,3'b101,Z3, 3'b100,3'b010,L0,L0,(k == 30) ? 3'b010 : Z3,L0,L0));
    end
    step(mk("ab_drop",  L0,L1,3'b100,Z3,E7,Z3, Z3,Z3,L0,L0,Z3,L0,L0));
    step(mk("ab_drop2", L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));
    step(mk("ab_dec",   L0,L1,3'b010,Z3,E7,Z3, Z3,Z3,L0,L0,Z3,L0,L0));
    step(mk("ab_lf2",   L0,L0,3'b010,Z3,E7,Z3, 3'b010,3'b100,L1,L1,Z3,L0,L0));
    step(mk("ab_par",   L0,L0,3'b010,Z3,E7,Z3, 3'b010,Z3,L0,L0,Z3,L0,L0));
    step(mk("ab_lp",    L0,L0,Z3,Z3,E7,Z3,     3'b010,3'b100,L0,L1,Z3,L0,L0));
    step(mk("ab_chk",   L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L1,Z3,L1,L0));
    step(mk("ab_end",   L0,L0,Z3,Z3,E7,Z3,     Z3,Z3,L0,L0,Z3,L0,L0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
